// File: rtl/text_terminal_writer.sv
// text_terminal_writer
//   Converts the received UART byte stream into terminal-style writes to the
//   text character memory. It keeps a cursor and interprets CR, LF, BS and FF
//   (FF clears the screen). A small FIFO holds bytes that arrive while a clear
//   is running.
//
// Ports
//   clock           clk_40 system clock
//   reset           asynchronous, active-high reset
//   uart_data       received byte, stable while uart_data_ready is high
//   uart_data_ready level from the receiver (clk_1 domain), one byte per rise
//   mem_data        character code to write
//   mem_address     cell address, row*COLS+col
//   mem_write       one-cycle write strobe (held high for the whole clear)
//   cursor_col      current column, 0..COLS-1
//   cursor_row      current row, 0..ROWS-1
//   busy            high while a screen clear runs
//   overflow        sticky: a byte was dropped because the FIFO was full
module text_terminal_writer #(
  parameter int COLS       = 100,
  parameter int ROWS       = 37,
  parameter int ADDR_W     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        uart_data,
  input  logic              uart_data_ready,
  output logic [7:0]        mem_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic [6:0]        cursor_col,
  output logic [5:0]        cursor_row,
  output logic              busy,
  output logic              overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS*ROWS-1);
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic {IDLE, CLEAR} state_t;

  // ---------------------------------------------------------------------------
  // Input capture: [0],[1] synchronise, [2] is the previous synchronised level
  // ---------------------------------------------------------------------------
  logic [2:0] sync_q;
  logic       rise;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= 3'b000;
    else       sync_q <= {sync_q[1:0], uart_data_ready};
  end

  assign rise = sync_q[1] & ~sync_q[2];

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          full, empty, push, pop;
  logic          overflow_q;
  state_t        state_q;
  logic [7:0]    head;

  assign full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push  = rise & ~full;
  assign pop   = (state_q == IDLE) & ~empty;
  assign head  = fifo_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= uart_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      if (rise & full) overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Cursor arithmetic
  // ---------------------------------------------------------------------------
  logic [6:0]        col_q;
  logic [5:0]        row_q;
  logic [ADDR_W-1:0] cell_addr;
  logic [5:0]        row_next;
  logic              col_last;

  assign cell_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
  assign col_last  = (col_q == 7'(COLS-1));
  // No scrolling: the row wraps back to the top.
  assign row_next  = (row_q == 6'(ROWS-1)) ? 6'd0 : row_q + 6'd1;

  // ---------------------------------------------------------------------------
  // FSM with registered memory-port outputs
  // ---------------------------------------------------------------------------
  logic [7:0]        mem_data_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_write_q;
  logic              busy_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
    end else begin
      mem_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            case (head)
              8'h0D: col_q <= '0;
              8'h0A: row_q <= row_next;
              8'h08: begin
                if (col_q != '0) begin
                  col_q       <= col_q - 7'd1;
                  mem_data_q  <= SPACE;
                  mem_addr_q  <= cell_addr - ADDR_W'(1);
                  mem_write_q <= 1'b1;
                end
              end
              8'h0C: begin
                // The first clear write (address 0) issues right away so that
                // busy and mem_write cover the same 3700 cycles.
                state_q     <= CLEAR;
                busy_q      <= 1'b1;
                mem_data_q  <= SPACE;
                mem_addr_q  <= '0;
                mem_write_q <= 1'b1;
              end
              default: begin
                if (head >= 8'h20 && head <= 8'h7E) begin
                  mem_data_q  <= head;
                  mem_addr_q  <= cell_addr;
                  mem_write_q <= 1'b1;
                  if (col_last) begin
                    col_q <= '0;
                    row_q <= row_next;
                  end else begin
                    col_q <= col_q + 7'd1;
                  end
                end
              end
            endcase
          end
        end
        CLEAR: begin
          // mem_addr_q holds the address written in the current cycle.
          if (mem_addr_q == LAST_ADDR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
          end else begin
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            mem_write_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_data    = mem_data_q;
  assign mem_address = mem_addr_q;
  assign mem_write   = mem_write_q;
  assign cursor_col  = col_q;
  assign cursor_row  = row_q;
  assign busy        = busy_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_text_terminal_writer.sv
module tb_text_terminal_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  uart_data = 8'h00;
  logic        uart_data_ready = 1'b0;
  logic [7:0]  mem_data;
  logic [12:0] mem_address;
  logic        mem_write;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [12:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wq[$];

  text_terminal_writer dut (
    .clock(clock), .reset(reset),
    .uart_data(uart_data), .uart_data_ready(uart_data_ready),
    .mem_data(mem_data), .mem_address(mem_address), .mem_write(mem_write),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .busy(busy), .overflow(overflow)
  );

  always #12.5 clock = ~clock;

  always @(negedge clock) begin
    if (mem_write) wq.push_back('{a: mem_address, d: mem_data});
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    uart_data = b;
    uart_data_ready = 1'b1;
    repeat (3) @(negedge clock);
    uart_data_ready = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_clear_done(input string tag);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_clear(input string tag, input int base);
    int errs;
    errs = 0;
    for (int i = 0; i < 3700; i++)
      if (wq[base+i].a != 13'(i) || wq[base+i].d != 8'h20) errs++;
    chk(tag, errs, 0);
  endtask

  initial begin
    int b0, n;
    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_wr",   {31'd0, mem_write}, 0);
    chk("rst_addr", {19'd0, mem_address}, 0);
    chk("rst_cur",  {19'd0, cursor_row, cursor_col}, 0);
    chk("rst_flags",{30'd0, busy, overflow}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Latency: write visible after the 4th edge that sees ready high
    uart_data = 8'h41;
    uart_data_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("lat3_wr", {31'd0, mem_write}, 0);
    @(posedge clock);
    @(negedge clock);
    chk("lat4_wr",   {31'd0, mem_write}, 1);
    chk("lat4_addr", {19'd0, mem_address}, 0);
    chk("lat4_data", {24'd0, mem_data}, 32'h41);
    chk("lat4_cur",  {25'd0, cursor_col}, 1);
    chk("lat4_ovf",  {31'd0, overflow}, 0);
    @(negedge clock);
    chk("strobe_1cyc", {31'd0, mem_write}, 0);
    uart_data_ready = 1'b0;
    repeat (3) @(negedge clock);

    // Wrap from column 99 to next row
    for (int i = 0; i < 98; i++) send(8'h41);
    chk("col99", {25'd0, cursor_col}, 99);
    wq.delete();
    send(8'h42);
    chk("eol_nwr", wq.size(), 1);
    if (wq.size() >= 1) chk("eol_wr", {wq[0].a, wq[0].d}, {13'd99, 8'h42});
    chk("eol_cur", {19'd0, cursor_row, cursor_col}, {19'd0, 6'd1, 7'd0});

    // Bottom-right corner wraps to (0,0)
    for (int i = 0; i < 35; i++) send(8'h0A);
    for (int i = 0; i < 99; i++) send(8'h61);
    chk("pre_corner", {19'd0, cursor_row, cursor_col}, {19'd0, 6'd36, 7'd99});
    wq.delete();
    send(8'h43);
    chk("corner_nwr", wq.size(), 1);
    if (wq.size() >= 1) chk("corner_wr", {wq[0].a, wq[0].d}, {13'd3699, 8'h43});
    chk("corner_cur", {19'd0, cursor_row, cursor_col}, 0);

    // Control codes
    send(8'h41); send(8'h42);
    wq.delete();
    send(8'h08);
    chk("bs_nwr", wq.size(), 1);
    if (wq.size() >= 1) chk("bs_wr", {wq[0].a, wq[0].d}, {13'd1, 8'h20});
    chk("bs_col", {25'd0, cursor_col}, 1);
    wq.delete();
    send(8'h0D); send(8'h08);
    chk("cr_bs_nwr", wq.size(), 0);
    chk("cr_bs_cur", {19'd0, cursor_row, cursor_col}, 0);
    send(8'h0A);
    send(8'h07);
    chk("lf_nwr", wq.size(), 0);
    chk("lf_cur", {19'd0, cursor_row, cursor_col}, {19'd0, 6'd1, 7'd0});

    // Screen clear with bytes queued behind it
    wq.delete();
    b0 = busy_cnt;
    send(8'h0C);
    chk("clr_busy", {31'd0, busy}, 1);
    send(8'h78); send(8'h79); send(8'h7A);
    wait_clear_done("clr_done");
    repeat (30) @(negedge clock);
    chk("clr_len", busy_cnt - b0, 3700);
    chk("clr_nwr", wq.size(), 3703);
    if (wq.size() >= 3703) begin
      chk_clear("clr_seq", 0);
      chk("clr_x", {wq[3700].a, wq[3700].d}, {13'd0, 8'h78});
      chk("clr_y", {wq[3701].a, wq[3701].d}, {13'd1, 8'h79});
      chk("clr_z", {wq[3702].a, wq[3702].d}, {13'd2, 8'h7A});
    end
    chk("clr_cur", {19'd0, cursor_row, cursor_col}, 3);
    chk("ovf_pre", {31'd0, overflow}, 0);

    // Overflow: five bytes into a four-entry FIFO during a clear
    wq.delete();
    send(8'h0C);
    for (int i = 0; i < 5; i++) send(8'h31 + 8'(i));
    chk("ovf_set", {31'd0, overflow}, 1);
    wait_clear_done("ovf_clr_done");
    repeat (30) @(negedge clock);
    chk("ovf_nwr", wq.size(), 3704);
    if (wq.size() >= 3704)
      for (int i = 0; i < 4; i++)
        chk("ovf_keep", {wq[3700+i].a, wq[3700+i].d}, {13'(i), 8'h31 + 8'(i)});
    send(8'h5A);
    chk("ovf_sticky", {31'd0, overflow}, 1);

    // Reset in the middle of a clear
    send(8'h0C);
    n = 0;
    while (!(mem_write && mem_address == 13'd1000) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("mid_reach", {31'd0, mem_write}, 1);
    reset = 1'b1;
    #1;
    chk("arst_wr",   {31'd0, mem_write}, 0);
    chk("arst_addr", {19'd0, mem_address}, 0);
    chk("arst_data", {24'd0, mem_data}, 0);
    chk("arst_cur",  {19'd0, cursor_row, cursor_col}, 0);
    chk("arst_flags",{30'd0, busy, overflow}, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    wq.delete();
    repeat (20) @(negedge clock);
    chk("arst_nowr", wq.size(), 0);
    send(8'h51);
    chk("q_nwr", wq.size(), 1);
    if (wq.size() >= 1) chk("q_wr", {wq[0].a, wq[0].d}, {13'd0, 8'h51});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_terminal_writer.md
Name: text_terminal_writer

Overview:
- Sits between uart_receiver and text_memory, in place of the plain byte-to-address controller path.
- Turns the received byte stream into terminal-style writes to the text character memory, one cell per byte.
- Keeps a cursor, interprets CR, LF, BS and FF (clear screen), and buffers bytes in a small FIFO so none are lost while a clear is in progress.
- Runs on clk_40 and drives mem_data, mem_address and mem_write of text_memory.

Parameters:
COLS, 100, characters per row (800 px / 8 px glyph)
ROWS, 37, character rows (600 px / 16 px glyph)
ADDR_W, 13, memory address width; must satisfy COLS*ROWS <= 2^ADDR_W
FIFO_DEPTH, 4, input byte FIFO entries (power of two)

Ports:
clock  input  1  clk_40 system clock
reset  input  1  asynchronous, active-high reset
uart_data  input  8  received byte; stable while uart_data_ready is high
uart_data_ready  input  1  level from uart_receiver in clk_1 domain; one byte per rising edge
mem_data  output  8  character code to write
mem_address  output  ADDR_W  cell address, row*COLS+col
mem_write  output  1  one-cycle write strobe
cursor_col  output  7  current column, 0..COLS-1
cursor_row  output  6  current row, 0..ROWS-1
busy  output  1  high while screen clear runs
overflow  output  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, active-high), all outputs 0:
  - mem_data, mem_address, mem_write, cursor_col, cursor_row, busy and overflow all 0.
  - FIFO empty, synchroniser flops 0, FSM in IDLE.
- Reset mid-clear: the clear aborts immediately; no further writes occur.
- Input capture:
  - uart_data_ready passes through a 2-flop synchroniser; the rising edge of the synchronised level is detected.
  - On the detect cycle uart_data is pushed into the FIFO.
  - Push while full: byte dropped and overflow set, even if a pop occurs in the same cycle. overflow clears only on reset.
- FSM states: IDLE, CLEAR.
- IDLE, FIFO non-empty: pop one byte per cycle. The decoded effect registers on the same edge, so mem_write is high in the following cycle.
- Byte decode in IDLE:
  - 0x20..0x7E: write byte at (row,col), then advance the cursor. col==COLS-1 sets col=0 and row+1; row==ROWS-1 with row+1 wraps row to 0 (no scrolling).
  - 0x0D CR: col=0, no write.
  - 0x0A LF: row+1 with wrap, col unchanged, no write.
  - 0x08 BS: if col>0, col-1 and write 0x20 at the new position; if col==0, no-op (no row retreat).
  - 0x0C FF: enter CLEAR, busy=1.
  - All other codes: ignored, no write, cursor unchanged.
- CLEAR state:
  - Writes 0x20 to addresses 0..COLS*ROWS-1 in ascending order, one per cycle, with mem_write continuously high. This is 3700 cycles at the default parameters.
  - After the last write: cursor=(0,0), busy=0, return to IDLE.
  - FIFO pushes continue during CLEAR; no pops occur.
- mem_address arithmetic: computed at full ADDR_W width, never exceeds COLS*ROWS-1.
- mem_data, mem_address and mem_write are registered outputs. mem_data and mem_address hold their last values when mem_write=0.
- Latency: mem_write asserts on the 4th clock edge after the first edge that samples uart_data_ready high, with the FIFO empty and the FSM in IDLE. The 4 edges are 2 sync, 1 push, 1 pop/write.
- Throughput: one byte per cycle, so the FIFO never fills at UART rates except during CLEAR.
- cursor_col and cursor_row update on the same edge that mem_write asserts.

Test Plan:
- After reset, send 'A' (0x41) → one mem_write pulse with addr 0, data 0x41, exactly 4 cycles after ready rises; cursor=(0,1); overflow=0.
- From col 99 row 0, send 0x42 → write addr 99; cursor=(1,0). From row 36 col 99, send 0x43 → write addr 3699; cursor=(0,0).
- Send "AB", then 0x08 → write addr 1 with 0x20; cursor col=1. Then 0x0D, 0x08 → no write; cursor (0,0). Then 0x0A → row 1, no write.
- Send 0x0C → busy high for 3700 cycles; writes of 0x20 cover addr 0..3699 in order; cursor ends (0,0). Pulse ready 3 more times during the clear with 'x','y','z' → after busy falls, writes land at addr 0,1,2 in order.
- During a clear, pulse ready 5 times → first 4 bytes retained, 5th dropped, overflow=1 and stays 1 until reset.
- Assert reset at clear address 1000 → all outputs 0 asynchronously; no mem_write after release. A following 'Q' writes addr 0.
